// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch controller, its top level and the
// seven-segment decoders: the mode encoding (state_t) and the default
// prescaler, counter-limit and time-width constants.
// ---------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_PAUSED  = 3'b000,
      ST_RUNNING = 3'b001,
      ST_CLEAR   = 3'b010,
      ST_IDLE    = 3'b100
   } state_t;

   localparam int DEF_DIV_COUNT = 100;
   localparam int DEF_TIME_W    = 5;
   localparam int DEF_MAX_COUNT = 31;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl_if
// Button inputs and display/status outputs of the stopwatch controller.
//   start_i, clear_i, lap_i : synchronized button levels
//   mode_o                  : current mode (state_t encoding)
//   time_o / lap_o          : live elapsed count / captured lap value
//   show_lap_o              : display shows lap_o instead of time_o
//   disp_o                  : value for the seven-segment decoders
//   tick_o                  : one-cycle count-tick pulse
//   overflow_o              : sticky wrap flag
// Modports: master drives the buttons (board top / bench), slave is the
// controller.
// ---------------------------------------------------------------------------
interface stopwatch_ctrl_if #(
   parameter int TIME_W = 5
);
   logic              start_i;
   logic              clear_i;
   logic              lap_i;
   logic [2:0]        mode_o;
   logic [TIME_W-1:0] time_o;
   logic [TIME_W-1:0] lap_o;
   logic              show_lap_o;
   logic [TIME_W-1:0] disp_o;
   logic              tick_o;
   logic              overflow_o;

   modport master (
      output start_i, clear_i, lap_i,
      input  mode_o, time_o, lap_o, show_lap_o, disp_o, tick_o, overflow_o
   );

   modport slave (
      input  start_i, clear_i, lap_i,
      output mode_o, time_o, lap_o, show_lap_o, disp_o, tick_o, overflow_o
   );
endinterface

// File: rtl/stopwatch_prescaler.sv
// ---------------------------------------------------------------------------
// stopwatch_prescaler
// Divides clk into count ticks. Counts 0..DIV_COUNT-1 while en_i is high and
// holds its value otherwise, so a paused stopwatch keeps its fractional
// second. clr_i zeroes the count.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : count enable (stopwatch running)
//   clr_i      : synchronous clear
//   tick_o     : combinational, high in the last cycle of each period
// ---------------------------------------------------------------------------
module stopwatch_prescaler #(
   parameter int DIV_COUNT = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int CNT_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt;

   // Prescaler count: clear has priority, then count/wrap while enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= {CNT_W{1'b0}};
      end else if (clr_i) begin
         cnt <= {CNT_W{1'b0}};
      end else if (en_i) begin
         if (cnt == LAST) begin
            cnt <= {CNT_W{1'b0}};
         end else begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt <= cnt;
      end
   end

   assign tick_o = en_i & (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencing controller for the stopwatch: button edge detection, the
// IDLE/RUNNING/PAUSED/CLEAR mode FSM, elapsed-time counter with sticky
// overflow, and lap capture.
//   clk   : system clock (100 Hz board clock)
//   reset : synchronous, active-high reset
//   bus   : stopwatch_ctrl_if.slave (buttons in, display/status out)
// Optional feature macro: STOPWATCH_LAP_EN. When undefined, lap_i is ignored,
// lap_o and show_lap_o are tied to 0 and disp_o follows time_o.
// ---------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIV_COUNT = DEF_DIV_COUNT,
   parameter int TIME_W    = DEF_TIME_W,
   parameter int MAX_COUNT = DEF_MAX_COUNT
) (
   input logic            clk,
   input logic            reset,
   stopwatch_ctrl_if.slave bus
);
   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] RUNNING = ST_RUNNING;
   localparam logic [2:0] PAUSED  = ST_PAUSED;
   localparam logic [2:0] CLEAR   = ST_CLEAR;
   localparam logic [TIME_W-1:0] TIME_MAX = TIME_W'(MAX_COUNT);
   localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic              start_q;
   logic              clear_q;
   logic              start_ev;
   logic              clear_ev;
   logic              tick;
   logic [TIME_W-1:0] time_cnt;
   logic              overflow;
   logic [TIME_W-1:0] lap_val;
   logic              show_lap;

   assign start_ev = bus.start_i & ~start_q;
   assign clear_ev = bus.clear_i & ~clear_q;

   // Start/clear button history; keeps updating in CLEAR so held buttons never re-fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         start_q <= bus.start_i;
         clear_q <= bus.clear_i;
      end
   end

   // Mode FSM next state; clear beats start in IDLE/PAUSED, CLEAR drops all events.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, PAUSED: begin
            if (clear_ev) begin
               state_nxt = CLEAR;
            end else if (start_ev) begin
               state_nxt = RUNNING;
            end else begin
               state_nxt = state;
            end
         end
         RUNNING: begin
            if (start_ev) begin
               state_nxt = PAUSED;
            end else begin
               state_nxt = RUNNING;
            end
         end
         CLEAR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Mode register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   stopwatch_prescaler #(.DIV_COUNT(DIV_COUNT)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .en_i   (state == RUNNING),
      .clr_i  (state == CLEAR),
      .tick_o (tick)
   );

   // Elapsed-time counter and sticky overflow; a start event never suppresses a coinciding tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         time_cnt <= {TIME_W{1'b0}};
         overflow <= 1'b0;
      end else if (state == CLEAR) begin
         time_cnt <= {TIME_W{1'b0}};
         overflow <= 1'b0;
      end else if (tick) begin
         if (time_cnt == TIME_MAX) begin
            time_cnt <= {TIME_W{1'b0}};
            overflow <= 1'b1;
         end else begin
            time_cnt <= time_cnt + TIME_ONE;
            overflow <= overflow;
         end
      end else begin
         time_cnt <= time_cnt;
         overflow <= overflow;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_q;
   logic lap_ev;

   assign lap_ev = bus.lap_i & ~lap_q;

   // Lap button history.
   always_ff @(posedge clk) begin
      if (reset) begin
         lap_q <= 1'b0;
      end else begin
         lap_q <= bus.lap_i;
      end
   end

   // Lap capture: RUNNING latches the pre-tick time, PAUSED returns the display to live time.
   always_ff @(posedge clk) begin
      if (reset) begin
         lap_val  <= {TIME_W{1'b0}};
         show_lap <= 1'b0;
      end else if (state == CLEAR) begin
         lap_val  <= {TIME_W{1'b0}};
         show_lap <= 1'b0;
      end else if (lap_ev && (state == RUNNING)) begin
         lap_val  <= time_cnt;
         show_lap <= 1'b1;
      end else if (lap_ev && (state == PAUSED)) begin
         lap_val  <= lap_val;
         show_lap <= 1'b0;
      end else begin
         lap_val  <= lap_val;
         show_lap <= show_lap;
      end
   end
`else
   logic unused_lap;

   assign unused_lap = bus.lap_i;
   assign lap_val    = {TIME_W{1'b0}};
   assign show_lap   = 1'b0;
`endif

   assign bus.mode_o     = state;
   assign bus.time_o     = time_cnt;
   assign bus.lap_o      = lap_val;
   assign bus.show_lap_o = show_lap;
   assign bus.disp_o     = show_lap ? lap_val : time_cnt;
   assign bus.tick_o     = tick;
   assign bus.overflow_o = overflow;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch datapath. It edge-detects start/stop, clear and lap buttons and runs the IDLE/RUNNING/PAUSED/CLEAR mode FSM. It divides the 100 Hz board clock into count ticks and maintains the elapsed-time counter plus a lap capture register. Its outputs feed the ones/tens seven-segment decoders and the mode LEDs in the FPGA top level.

Parameters:
DIV_COUNT, 100, clk cycles per count tick (100 Hz clock -> 1 s); legal range >= 2
TIME_W, 5, width of time/lap values
MAX_COUNT, 31, last count value before wrap; must be <= 2**TIME_W-1

Ports:
clk  in  1  system clock (hz100 at top level)
reset  in  1  synchronous, active-high reset
start_i  in  1  start/stop button level, already synchronized to clk
clear_i  in  1  clear button level, already synchronized
lap_i  in  1  lap button level, already synchronized
mode_o  out  3  current state (state_t)
time_o  out  TIME_W  live elapsed count
lap_o  out  TIME_W  captured lap value
show_lap_o  out  1  display currently shows lap_o
disp_o  out  TIME_W  value for the decoders: show_lap_o ? lap_o : time_o (combinational)
tick_o  out  1  one-cycle count-tick pulse
overflow_o  out  1  sticky flag: counter has wrapped

Behaviour:
- Reset (sync, wins over everything, including mid-count): mode_o=IDLE, time_o=0, lap_o=0, show_lap_o=0, overflow_o=0, tick_o=0, prescaler=0, button history regs=0.
- Press event = level & ~prev_q. One cycle per rising edge. Holding a button gives no repeats. Events are acted on at the same edge that samples the level high, so mode_o changes 1 cycle after the button rises.
- States: IDLE=3'b100, RUNNING=3'b001, PAUSED=3'b000, CLEAR=3'b010.
- IDLE: start -> RUNNING; clear -> CLEAR; if both, clear wins.
- RUNNING: start -> PAUSED. Clear is ignored. Lap is handled as described below.
- PAUSED: start -> RUNNING; clear -> CLEAR; if both, clear wins.
- CLEAR: lasts exactly 1 cycle and zeroes time_o, lap_o, show_lap_o, overflow_o and the prescaler. Always -> IDLE. All button events in this cycle are dropped.
- Prescaler: counts 0..DIV_COUNT-1 only while RUNNING and holds its value in IDLE/PAUSED, so resume keeps the fractional second.
- tick_o=1 combinationally while RUNNING and prescaler==DIV_COUNT-1. At that edge the prescaler goes to 0 and time_o increments; the new value is visible in the next cycle.
- Wrap: a tick with time_o==MAX_COUNT sets time_o=0 and overflow_o=1. overflow_o stays set until CLEAR or reset.
- A start event in the same cycle as a tick: the tick is still applied before the state changes to PAUSED.
- Lap in RUNNING: each press sets lap_o<=time_o (the pre-increment value if a tick coincides) and show_lap_o<=1.
- Lap in PAUSED: a press clears show_lap_o, returning the display to live time. Lap in IDLE/CLEAR is ignored.
- Start and lap together in RUNNING: both are applied (capture, then pause).

Optional Feature:
STOPWATCH_LAP_EN.
- Defined: lap behaviour exactly as above.
- Undefined: lap_i is ignored (port is kept); lap_o=0, show_lap_o=0, disp_o=time_o; no lap registers are synthesized.

Decomposition:
- Package stopwatch_pkg holds the state_t enum with the encodings above and the default DIV_COUNT/MAX_COUNT constants, shared with the top level and the decoders.
- One sub-module, stopwatch_prescaler (parameter DIV_COUNT; inputs clk, reset, en_i, clr_i; output tick_o).
- FSM, counter, edge detection and lap logic stay in stopwatch_ctrl.

Test Plan (DIV_COUNT=4, MAX_COUNT=31):
- Reset, then press start -> mode_o=RUNNING next cycle; tick_o every 4th cycle; time_o=3 after 3 ticks.
- RUNNING at time 5 with prescaler=2, press start -> PAUSED, time_o holds 5 for 20 cycles. Press start -> the next tick comes 1 cycle after resume; time_o=6.
- Run to time_o=31, then one more tick -> time_o=0, overflow_o=1. Pause, press clear -> one cycle in CLEAR, then IDLE with time_o=0, overflow_o=0.
- RUNNING at time 7, press lap -> lap_o=7, show_lap_o=1, disp_o=7 while time_o advances to 9. Pause, press lap -> show_lap_o=0, disp_o=9. Without STOPWATCH_LAP_EN: lap_o=0, disp_o=time_o throughout.
- Hold start high for 50 cycles -> exactly one transition. Press start and clear together in PAUSED -> CLEAR taken.
- Assert reset mid-RUNNING at time 12 -> next cycle: all outputs at reset values and mode_o=IDLE.
